// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder : single-outstanding 32-bit word memory with fixed response latency
// Optional macro MEM_RSP_ERR_EN enables address error checking.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         c_DEPTH    = 1 << ADDR_W;
  localparam bit         c_ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] c_LAT_M1   = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [c_DEPTH];

  logic              w_enter_resp;
  logic              w_src_wr;
  logic [31:0]       w_src_addr;
  logic [31:0]       w_src_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic [31:0]       w_rdata;

  // With zero latency the access happens on the accept edge, straight from the request bus.
  assign w_enter_resp = c_ZERO_LAT ? (state_q == IDLE && req_valid)
                                   : (state_q == WAIT && cnt_q == 4'd0);
  assign w_src_wr     = c_ZERO_LAT ? req_write : wr_q;
  assign w_src_addr   = c_ZERO_LAT ? req_addr  : addr_q;
  assign w_src_wdata  = c_ZERO_LAT ? req_wdata : wdata_q;
  assign w_idx        = w_src_addr[ADDR_W+1:2];

`ifdef MEM_RSP_ERR_EN
  assign w_err = (w_src_addr[1:0] != 2'b00) || ((w_src_addr >> (ADDR_W + 2)) != 32'd0);
`else
  logic w_unused_addr;
  assign w_err         = 1'b0;
  assign w_unused_addr = ^{w_src_addr[1:0], w_src_addr[31:ADDR_W+2]};
`endif

  assign w_rdata = (w_src_wr || w_err) ? 32'd0 : mem_q[w_idx];

  // Storage is deliberately outside reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_src_wr && !w_err) begin
      mem_q[w_idx] <= w_src_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
            cnt_q       <= c_LAT_M1;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (w_enter_resp) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rdata_q     <= w_rdata;
        err_q       <= w_err;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire
